// File: rtl/draw_arb_pkg.sv
// Shared types and widths for the draw-engine arbiter.
// Covers the arbiter state encoding, VGA coordinate widths and engine indices.
package draw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int X_W  = 8;
  localparam int Y_W  = 7;
  localparam int C_W  = 3;
  localparam int ID_W = 2;

  localparam int PADDLE = 0;
  localparam int BALL   = 1;
  localparam int BRICKS = 2;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
// Returns the first requesting index strictly after last_grant, wrapping around.
module rr_picker
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               found,
  output logic [ID_W-1:0]    pick
);

  logic [ID_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    // The last offset lands on last_grant itself, so a lone requester can be re-granted.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin owner of the single VGA pixel-write port, shared by the draw engines.
// state   | meaning
// IDLE    | no grant; pick the next requester after last_grant
// BUSY    | one engine owns enable_state, its pixels are registered to VGA
// RELEASE | dead cycle so two engines never see enable_state back to back
module draw_arbiter
  import draw_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clock,
  input  logic                   reset_state,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     client_done,
  input  logic [NUM_REQ-1:0]     client_plot,
  input  logic [X_W*NUM_REQ-1:0] client_x,
  input  logic [Y_W*NUM_REQ-1:0] client_y,
  input  logic [C_W*NUM_REQ-1:0] client_colour,
  output logic [NUM_REQ-1:0]     enable_state,
  output logic [ID_W-1:0]        grant_id,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour_out,
  output logic                   plot,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  last_grant;
  logic [CNT_W-1:0] cnt;
  logic             found;
  logic [ID_W-1:0]  pick;
  logic             start_grant;
  logic             end_grant;
  logic             timeout_hit;
  logic             cur_done;
  logic             cur_req;

  logic [X_W-1:0] cl_x [NUM_REQ];
  logic [Y_W-1:0] cl_y [NUM_REQ];
  logic [C_W-1:0] cl_c [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign cl_x[i] = client_x[X_W*i +: X_W];
    assign cl_y[i] = client_y[Y_W*i +: Y_W];
    assign cl_c[i] = client_colour[C_W*i +: C_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .found      (found),
    .pick       (pick)
  );

  assign cur_done = client_done[grant_id];
  assign cur_req  = req[grant_id];
  assign busy     = (state == BUSY);

  always_ff @(posedge clock or posedge reset_state) begin
    if (reset_state) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_grant = 1'b0;
    end_grant   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt   = BUSY;
          start_grant = 1'b1;
        end
      end
      BUSY: begin
        // Done or abandon wins over a coincident timeout, so no error is flagged then.
        if (cur_done || !cur_req) begin
          state_nxt = RELEASE;
          end_grant = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = RELEASE;
          end_grant   = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset_state) begin
    if (reset_state) begin
      enable_state <= '0;
      grant_id     <= '0;
      last_grant   <= ID_W'(NUM_REQ - 1);
      cnt          <= '0;
      timeout_err  <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (start_grant) begin
        grant_id     <= pick;
        enable_state <= NUM_REQ'(1) << pick;
        cnt          <= '0;
      end else if (end_grant) begin
        enable_state <= '0;
        last_grant   <= grant_id;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Coordinates hold outside BUSY; only the write enable is forced low.
  always_ff @(posedge clock or posedge reset_state) begin
    if (reset_state) begin
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour_out <= '0;
    end else if (state == BUSY) begin
      plot       <= client_plot[grant_id];
      x          <= cl_x[grant_id];
      y          <= cl_y[grant_id];
      colour_out <= cl_c[grant_id];
    end else begin
      plot <= 1'b0;
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: two instances (long and short timeout) share stimulus and are
// compared every cycle against a grant/ownership model, plus directed literal expectations.
module tb_draw_arbiter;
  import draw_arb_pkg::*;

  localparam int N    = 3;
  localparam int TO_A = 4096;
  localparam int TO_B = 16;

  logic clock = 1'b0;
  logic reset_state;
  logic [N-1:0]     req, client_done, client_plot;
  logic [X_W*N-1:0] client_x;
  logic [Y_W*N-1:0] client_y;
  logic [C_W*N-1:0] client_colour;

  logic [N-1:0] en_a, en_b;
  logic [1:0]   gid_a, gid_b;
  logic [7:0]   x_a, x_b;
  logic [6:0]   y_a, y_b;
  logic [2:0]   c_a, c_b;
  logic         plot_a, plot_b, busy_a, busy_b, terr_a, terr_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  draw_arbiter #(.NUM_REQ(N), .TIMEOUT(TO_A)) dut_a (
    .clock(clock), .reset_state(reset_state), .req(req), .client_done(client_done),
    .client_plot(client_plot), .client_x(client_x), .client_y(client_y),
    .client_colour(client_colour), .enable_state(en_a), .grant_id(gid_a), .x(x_a),
    .y(y_a), .colour_out(c_a), .plot(plot_a), .busy(busy_a), .timeout_err(terr_a));

  draw_arbiter #(.NUM_REQ(N), .TIMEOUT(TO_B)) dut_b (
    .clock(clock), .reset_state(reset_state), .req(req), .client_done(client_done),
    .client_plot(client_plot), .client_x(client_x), .client_y(client_y),
    .client_colour(client_colour), .enable_state(en_b), .grant_id(gid_b), .x(x_b),
    .y(y_b), .colour_out(c_b), .plot(plot_b), .busy(busy_b), .timeout_err(terr_b));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, for how long, and what the VGA register holds.
  int tmo       [2] = '{TO_A, TO_B};
  int m_granted [2] = '{0, 0};
  int m_gid     [2] = '{0, 0};
  int m_last    [2] = '{N-1, N-1};
  int m_age     [2] = '{0, 0};
  int m_dead    [2] = '{0, 0};
  int m_plot    [2] = '{0, 0};
  int m_x       [2] = '{0, 0};
  int m_y       [2] = '{0, 0};
  int m_c       [2] = '{0, 0};
  int m_terr    [2] = '{0, 0};

  function automatic int fld(input logic [31:0] v, input int idx, input int w);
    return int'((v >> (idx * w)) & ((32'd1 << w) - 32'd1));
  endfunction

  always @(posedge clock or posedge reset_state) begin
    int g, j;
    for (int i = 0; i < 2; i++) begin
      if (reset_state) begin
        m_granted[i] = 0; m_gid[i] = 0; m_last[i] = N - 1; m_age[i] = 0; m_dead[i] = 0;
        m_plot[i] = 0; m_x[i] = 0; m_y[i] = 0; m_c[i] = 0; m_terr[i] = 0;
      end else begin
        m_terr[i] = 0;
        if (m_granted[i] != 0) begin
          g = m_gid[i];
          m_plot[i] = int'(client_plot[g]);
          m_x[i] = fld(32'(client_x), g, X_W);
          m_y[i] = fld(32'(client_y), g, Y_W);
          m_c[i] = fld(32'(client_colour), g, C_W);
          if (client_done[g] || !req[g]) begin
            m_granted[i] = 0; m_dead[i] = 1; m_last[i] = g;
          end else if (m_age[i] == tmo[i] - 1) begin
            m_granted[i] = 0; m_dead[i] = 1; m_last[i] = g; m_terr[i] = 1;
          end else begin
            m_age[i]++;
          end
        end else begin
          m_plot[i] = 0;
          if (m_dead[i] != 0) m_dead[i] = 0;
          else begin
            for (int k = 1; k <= N; k++) begin
              j = (m_last[i] + k) % N;
              if (m_granted[i] == 0 && req[j]) begin
                m_granted[i] = 1; m_gid[i] = j; m_age[i] = 0;
              end
            end
          end
        end
      end
    end
  end

  task automatic chk_inst(input int i, input logic [2:0] en, input logic [1:0] gid,
                          input logic bsy, input logic pl, input logic [7:0] xx,
                          input logic [6:0] yy, input logic [2:0] cc, input logic te);
    int exp_en;
    exp_en = (m_granted[i] != 0) ? (1 << m_gid[i]) : 0;
    check(i == 0 ? "cyc_enable_a" : "cyc_enable_b", int'(en), exp_en);
    check(i == 0 ? "cyc_grant_id_a" : "cyc_grant_id_b", int'(gid), m_gid[i]);
    check(i == 0 ? "cyc_busy_a" : "cyc_busy_b", int'(bsy), m_granted[i]);
    check(i == 0 ? "cyc_plot_a" : "cyc_plot_b", int'(pl), m_plot[i]);
    check(i == 0 ? "cyc_x_a" : "cyc_x_b", int'(xx), m_x[i]);
    check(i == 0 ? "cyc_y_a" : "cyc_y_b", int'(yy), m_y[i]);
    check(i == 0 ? "cyc_colour_a" : "cyc_colour_b", int'(cc), m_c[i]);
    check(i == 0 ? "cyc_timeout_err_a" : "cyc_timeout_err_b", int'(te), m_terr[i]);
  endtask

  bit cap_on = 1'b0;
  int cap_x[$], cap_y[$], cap_c[$];

  always @(negedge clock) begin
    chk_inst(0, en_a, gid_a, busy_a, plot_a, x_a, y_a, c_a, terr_a);
    chk_inst(1, en_b, gid_b, busy_b, plot_b, x_b, y_b, c_b, terr_b);
    check("onehot_a", int'($onehot0(en_a)), 1);
    check("onehot_b", int'($onehot0(en_b)), 1);
    if (cap_on && plot_a) begin
      cap_x.push_back(int'(x_a));
      cap_y.push_back(int'(y_a));
      cap_c.push_back(int'(c_a));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset_state = 1'b1;
    tick();
    tick();
    reset_state = 1'b0;
  endtask

  function automatic int idx_of(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int gap, cnt;
    int exp_rr [5] = '{0, 1, 2, 0, 1};

    reset_state = 1'b1;
    req = '0; client_done = '0; client_plot = '0;
    client_x = '0; client_y = '0; client_colour = '0;
    repeat (3) tick();
    check("rst_outs_a", int'({en_a, gid_a, x_a, y_a, c_a, plot_a, busy_a, terr_a}), 0);
    check("rst_outs_b", int'({en_b, gid_b, x_b, y_b, c_b, plot_b, busy_b, terr_b}), 0);

    // reset asserted mid-grant, then first grant with all requesting goes to engine 0
    reset_state = 1'b0;
    req = 3'b111;
    tick();
    check("grant_latency", int'(en_a), 1);
    tick(); tick();
    #1 reset_state = 1'b1;
    #1;
    check("async_rst_enable", int'(en_a), 0);
    check("async_rst_busy", int'(busy_a), 0);
    tick(); tick();
    reset_state = 1'b0;
    tick();
    check("first_grant_after_rst", int'(en_a), 1);
    req = '0;
    repeat (3) tick();

    // single requester drawing a 21x3 block at (60,100)
    req = 3'b010;
    tick();
    check("single_grant", int'(en_a), 2);
    check("single_busy", int'(busy_a), 1);
    cap_on = 1'b1;
    for (int k = 0; k < 63; k++) begin
      client_plot   = 3'b010;
      client_x      = 24'((60 + k % 21) << 8);
      client_y      = 21'((100 + k / 21) << 7);
      client_colour = 9'((k % 8) << 3);
      tick();
    end
    client_plot = '0;
    client_done = 3'b010;
    tick();
    check("done_release", int'(en_a), 0);
    client_done = '0;
    req = '0;
    tick(); tick();
    cap_on = 1'b0;
    check("pix_count", cap_x.size(), 63);
    for (int k = 0; k < 63 && k < cap_x.size(); k++) begin
      check("pix_x", cap_x[k], 60 + k % 21);
      check("pix_y", cap_y[k], 100 + k / 21);
      check("pix_colour", cap_c[k], k % 8);
    end
    repeat (2) tick();

    // round-robin with every engine requesting, done on the 5th granted cycle
    do_reset();
    req = 3'b111;
    for (int n = 0; n < 5; n++) begin
      gap = 0;
      while (en_a == 0 && gap < 8) begin gap++; tick(); end
      if (n > 0) check("rr_gap", gap, 2);
      check("rr_order", idx_of(en_a), exp_rr[n]);
      repeat (4) tick();
      client_done = en_a;
      tick();
      client_done = '0;
    end
    req = '0;
    repeat (3) tick();

    // forced release on the short-timeout instance
    do_reset();
    req = 3'b100;
    tick();
    check("to_grant_b", int'(en_b), 4);
    cnt = 0;
    while (en_b != 0 && cnt < 40) begin
      cnt++;
      if (cnt == 3) req = 3'b101;
      tick();
    end
    check("to_length_b", cnt, TO_B);
    check("to_err_b", int'(terr_b), 1);
    tick();
    check("to_err_pulse_b", int'(terr_b), 0);
    tick();
    check("to_next_grant_b", int'(en_b), 1);
    req = '0;
    repeat (3) tick();

    // abandon mid-grant
    do_reset();
    req = 3'b010;
    tick();
    check("ab_grant_b", int'(en_b), 2);
    repeat (4) tick();
    req = '0;
    tick();
    check("ab_release_b", int'(en_b), 0);
    check("ab_err_b", int'(terr_b), 0);
    tick();
    check("ab_err_later_b", int'(terr_b), 0);

    // done on the last permitted cycle beats the timeout
    do_reset();
    req = 3'b010;
    tick();
    repeat (15) tick();
    check("coll_still_granted_b", int'(en_b), 2);
    client_done = 3'b010;
    tick();
    client_done = '0;
    check("coll_release_b", int'(en_b), 0);
    check("coll_err_b", int'(terr_b), 0);
    req = '0;
    repeat (3) tick();

    // isolation: non-granted engines toggle plot/done/coordinates
    do_reset();
    req = 3'b101;
    tick();
    check("iso_grant", int'(en_a), 1);
    for (int k = 0; k < 10; k++) begin
      client_plot   = {2'($urandom), k[0]};
      client_done   = {2'($urandom), 1'b0};
      client_x      = {16'($urandom), 8'd5};
      client_y      = {14'($urandom), 7'd6};
      client_colour = {6'($urandom), 3'd3};
      tick();
      check("iso_enable_a", int'(en_a), 1);
      check("iso_enable_b", int'(en_b), 1);
      check("iso_plot", int'(plot_a), k % 2);
      check("iso_xyc", int'({x_a, y_a, c_a}), int'({8'd5, 7'd6, 3'd3}));
    end
    client_plot = '0;
    client_done = 3'b001;
    tick();
    client_done = '0;
    check("iso_release", int'(en_a), 0);
    tick(); tick();
    check("iso_next_grant", int'(en_a), 4);
    req = '0;
    repeat (3) tick();

    // randomized traffic with one asynchronous reset in the middle
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int e = 0; e < N; e++) begin
        if ($urandom_range(0, 15) == 0) req[e] = ~req[e];
        client_done[e] = ($urandom_range(0, 19) == 0);
      end
      client_plot   = 3'($urandom);
      client_x      = 24'($urandom);
      client_y      = 21'($urandom);
      client_colour = 9'($urandom);
      if (c == 1500) reset_state = 1'b1;
      if (c == 1503) reset_state = 1'b0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
# draw_arbiter

Shares the single VGA pixel-write port between the game's drawing engines: paddle, ball and brick field. Each engine is a self-sequencing draw FSM with an `enable_state`/`done`/`plot` handshake. The arbiter grants one engine at a time in round-robin order and muxes that engine's pixel stream onto the VGA adaptor inputs through one register stage. It sits between the engine top levels and the VGA adaptor. It guarantees that only one engine plots at a time and that a hung engine cannot lock the screen.

## Interface

- NUM_REQ, 3: number of requesting engines; index 0 = paddle, 1 = ball, 2 = bricks.
- TIMEOUT, 4096: maximum grant length in cycles before a forced release.
- clock  in  1  system clock; all state changes on the rising edge.
- reset_state  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  level request per engine; held high until that engine's done or until it abandons.
- client_done  in  NUM_REQ  per-engine draw-complete pulse.
- client_plot  in  NUM_REQ  per-engine pixel-valid.
- client_x  in  8*NUM_REQ  packed x coordinates; engine i uses bits [8i+7:8i].
- client_y  in  7*NUM_REQ  packed y coordinates; engine i uses bits [7i+6:7i].
- client_colour  in  3*NUM_REQ  packed colours; engine i uses bits [3i+2:3i].
- enable_state  out  NUM_REQ  one-hot grant; drives each engine's enable_state.
- grant_id  out  2  index of the current or last granted engine.
- x  out  8  VGA x.
- y  out  7  VGA y.
- colour_out  out  3  VGA colour.
- plot  out  1  VGA write enable.
- busy  out  1  high while any engine holds the grant.
- timeout_err  out  1  one-cycle pulse on a forced release.

## Operation

- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - If any `req` bit is high, pick the first requesting index strictly after `last_grant`, wrapping modulo NUM_REQ.
  - Load `grant_id`, set the matching `enable_state` bit, clear the timeout counter, go to BUSY.
  - If no `req` bit is high, stay in IDLE.
- BUSY:
  - Exit to RELEASE when any of these holds: `client_done[grant_id]`, `req[grant_id]` low (abandon), or timeout counter == TIMEOUT-1.
  - On exit, clear `enable_state` and update `last_grant <= grant_id`.
  - If the exit is due to timeout and neither done nor abandon is present, pulse `timeout_err`. Done or abandon takes priority over timeout in the same cycle.
  - Otherwise, increment the timeout counter, which is 12 bits wide and sized by $clog2(TIMEOUT).
- RELEASE: one dead cycle with no grant; always go to IDLE. This guarantees that two engines never see `enable_state` in adjacent cycles.
- Pixel output register:
  - In BUSY, load `client_plot/x/y/colour` of `grant_id` every cycle.
  - In IDLE and RELEASE, load `plot` = 0; `x`, `y` and `colour_out` hold their values.
- `done`/`plot` bits of non-granted engines are ignored.
- A `req` rising while another engine is granted waits; it is never pre-empted.
- `busy` = (state == BUSY).

## Timing

- Reset values: state IDLE, `enable_state` 0, `grant_id` 0, `last_grant` = NUM_REQ-1 (so engine 0 wins first), `x` 0, `y` 0, `colour_out` 0, `plot` 0, `busy` 0, `timeout_err` 0, counter 0.
- Reset asserted mid-grant: all of the above apply immediately and asynchronously; the granted engine sees `enable_state` drop without `done`.
- Grant latency: `req` high in IDLE at edge t gives `enable_state` high after edge t+1.
- Pixel latency: engine `plot/x/y` at cycle c appear on the outputs at cycle c+1.
- End of grant:
  - `client_done` at cycle c gives `enable_state` low at c+1.
  - The pixel sampled at c is still emitted at c+1.
  - `plot` is 0 from c+2.
- Minimum turnaround between grants: BUSY exit, RELEASE, IDLE, next BUSY. This gives 2 cycles with `enable_state` all-zero.
- Forced release: the grant lasts exactly TIMEOUT cycles in BUSY, and `timeout_err` is high on the cycle `enable_state` falls.

## Structure

- Package `draw_arb_pkg`:
  - state enum (IDLE/BUSY/RELEASE);
  - coordinate widths (X_W=8, Y_W=7, C_W=3);
  - client index constants PADDLE=0, BALL=1, BRICKS=2.
- Sub-module `rr_picker`: combinational round-robin selector.
  - Inputs: `req`, `last_grant`.
  - Outputs: `found`, `pick`.
- The top level holds the FSM, the timeout counter and the output register.

## Test plan

- Reset: hold `reset_state` high mid-grant, then release. All outputs are 0, `enable_state`=000, and the first grant with `req`=111 goes to engine 0.
- Single requester: `req`=010 at edge t gives `enable_state`=010 at t+1 and `busy`=1. The engine plots 63 pixels (21x3 paddle-sized) starting at (60,100). VGA sees the same 63 pixels one cycle later. `done` gives `enable_state`=000 the next cycle.
- Round-robin fairness: `req`=111 held and each engine's `done` after 5 cycles. Grant order is 0,1,2,0,1. There are exactly 2 idle cycles between grants and `enable_state` is never multi-hot.
- Timeout (TIMEOUT=16): engine 2 granted and `done` never asserted. `enable_state` falls after 16 BUSY cycles with `timeout_err` high for 1 cycle. The next grant goes to engine 0 if it is requesting.
- Abandon, plus done/timeout collision:
  - `req[1]` dropped mid-grant gives release with no `timeout_err`.
  - `done` on cycle TIMEOUT-1 gives release with `timeout_err`=0.
- Isolation: a non-granted engine toggles `plot`, `done` and coordinates. The VGA outputs and FSM are unaffected.
